// File: rtl/brent_kung_sub_pipe.sv
// Three-stage pipelined subtractor (a - b - bin) with Brent-Kung borrow prefix.
// Valid/ready on both sides; stalls propagate back through a per-stage advance chain.
module brent_kung_sub_pipe #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LVL = $clog2(WIDTH);

    logic             rdy_q;
    logic             v1_q, v2_q, v3_q;
    logic             adv1, adv2, adv3;

    logic [WIDTH-1:0] g1_d, p1_d;
    logic [WIDTH-1:0] g1_q, p1_q;
    logic             cin1_q, am1_q;
    logic [TAG_W-1:0] tag1_q;

    logic [WIDTH-1:0] gu_d, pu_d;
    logic [WIDTH-1:0] gu_q, pu_q, p2_q;
    logic             cin2_q, am2_q;
    logic [TAG_W-1:0] tag2_q;

    logic [WIDTH-1:0] gd, cv, diff_d;
    logic             bout_d, ovf_d, zero_d;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q, ovf_q, zero_q;
    logic [TAG_W-1:0] tag3_q;

    // Advance chain: a stage may load when it is empty or the stage after it moves.
    always_comb begin
        adv3     = ~v3_q | out_ready;
        adv2     = ~v2_q | adv3;
        adv1     = ~v1_q | adv2;
        in_ready = adv1 & rdy_q;
    end

    // rdy_q keeps in_ready low until the first edge after reset releases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= 1'b1;
    end

    // Bitwise generate/propagate of a + ~b; a's msb is kept for the overflow test.
    always_comb begin
        g1_d = a & ~b;
        p1_d = a ^ ~b;
    end

    // Stage 1: operand-level generate/propagate, carry-in and tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            g1_q   <= '0;
            p1_q   <= '0;
            cin1_q <= 1'b0;
            am1_q  <= 1'b0;
            tag1_q <= '0;
        end else if (adv1) begin
            v1_q   <= in_valid & rdy_q;
            g1_q   <= g1_d;
            p1_q   <= p1_d;
            cin1_q <= ~bin;
            am1_q  <= a[WIDTH-1];
            tag1_q <= in_tag;
        end
    end

    // Up-sweep in place: node i at level l covers 2^l bits ending at i.
    // Carry-in is folded into bit 0 so every prefix already includes it.
    always_comb begin
        gu_d    = g1_q;
        pu_d    = p1_q;
        gu_d[0] = g1_q[0] | (p1_q[0] & cin1_q);
        for (int l = 1; l <= LVL; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (((i + 1) % (1 << l)) == 0) begin
                    gu_d[i] = gu_d[i] | (pu_d[i] & gu_d[i - (1 << (l - 1))]);
                    pu_d[i] = pu_d[i] & pu_d[i - (1 << (l - 1))];
                end
            end
        end
    end

    // Stage 2: up-sweep group terms plus the bitwise propagate for the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q   <= 1'b0;
            gu_q   <= '0;
            pu_q   <= '0;
            p2_q   <= '0;
            cin2_q <= 1'b0;
            am2_q  <= 1'b0;
            tag2_q <= '0;
        end else if (adv2) begin
            v2_q   <= v1_q;
            gu_q   <= gu_d;
            pu_q   <= pu_d;
            p2_q   <= p1_q;
            cin2_q <= cin1_q;
            am2_q  <= am1_q;
            tag2_q <= tag1_q;
        end
    end

    // Down-sweep fills the remaining prefixes from the nearest complete one below.
    always_comb begin
        gd = gu_q;
        for (int l = LVL - 1; l >= 1; l--) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << l) &&
                    ((i + 1) % (1 << l)) == (1 << (l - 1))) begin
                    gd[i] = gd[i] | (pu_q[i] & gd[i - (1 << (l - 1))]);
                end
            end
        end
        cv     = {gd[WIDTH-2:0], cin2_q};
        diff_d = p2_q ^ cv;
        bout_d = ~gd[WIDTH-1];
        // Operand signs differ exactly when the msb propagate is 0.
        ovf_d  = ~p2_q[WIDTH-1] & (diff_d[WIDTH-1] ^ am2_q);
        zero_d = ~|diff_d;
    end

    // Stage 3: final result flags and tag, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q   <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            tag3_q <= '0;
        end else if (adv3) begin
            v3_q   <= v2_q;
            diff_q <= diff_d;
            bout_q <= bout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            tag3_q <= tag2_q;
        end
    end

    assign out_valid = v3_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign out_tag   = tag3_q;

endmodule

// File: tb/tb_brent_kung_sub_pipe.sv
// Bench for brent_kung_sub_pipe: arithmetic reference model + in-order scoreboard,
// directed corner cases, backpressure, throughput and mid-stream reset.
module tb_brent_kung_sub_pipe;

    localparam int W  = 64;
    localparam int TW = 4;

    typedef struct packed {
        logic [W-1:0]  d;
        logic          bo;
        logic          ov;
        logic          z;
        logic [TW-1:0] t;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          bin = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  diff;
    logic          bout, ovf, zero;
    logic [TW-1:0] out_tag;

    int   errors = 0;
    int   checks = 0;
    int   n_neg = 0;
    int   pops = 0;
    int   last_acc_n = 0;
    int   last_pop_n = 0;
    int   stall_cnt = 0;
    logic rnd_ready = 1'b0;
    logic or_force = 1'b1;
    exp_t q[$];

    brent_kung_sub_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf), .zero(zero),
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [79:0] act,
                         input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic bi, input logic [TW-1:0] tg);
        exp_t                e;
        logic [W:0]          u;
        logic signed [W+1:0] s;
        u    = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
        s    = $signed({av[W-1], av[W-1], av}) - $signed({bv[W-1], bv[W-1], bv})
             - $signed({{(W+1){1'b0}}, bi});
        e.d  = u[W-1:0];
        e.bo = u[W];
        e.ov = (s != $signed({e.d[W-1], e.d[W-1], e.d}));
        e.z  = (e.d == '0);
        e.t  = tg;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] r;
        case ($urandom_range(0, 5))
            0:       r = '0;
            1:       r = '1;
            2:       r = {1'b1, {(W-1){1'b0}}};
            3:       r = {1'b0, {(W-1){1'b1}}};
            4:       r = W'($urandom_range(0, 15));
            default: r = {$urandom, $urandom};
        endcase
        return r;
    endfunction

    // Consumer ready: random when enabled, otherwise the forced level.
    always @(posedge clk) begin
        #2;
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : or_force;
    end

    // Scoreboard: push on accept, pop and compare on result handshake.
    logic       stall_q = 1'b0;
    logic [70:0] prev = '0;
    always @(negedge clk) begin
        exp_t e;
        n_neg++;
        if (!rst_n) begin
            q.delete();
            stall_q = 1'b0;
            check("reset_flags", 80'({in_ready, out_valid, bout, ovf, zero, out_tag}), 80'(0));
            check("reset_diff", 80'(diff), 80'(0));
        end else begin
            if (stall_q)
                check("hold_stable", 80'({out_valid, diff, bout, ovf, zero, out_tag}),
                      80'({1'b1, prev}));
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, bin, in_tag));
                last_acc_n = n_neg;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got tag %h with nothing pending", out_tag);
                end else begin
                    e = q.pop_front();
                    check("result", 80'({diff, bout, ovf, zero, out_tag}), 80'(e));
                    pops++;
                    last_pop_n = n_neg;
                end
            end
            stall_q = out_valid && !out_ready;
            prev    = {diff, bout, ovf, zero, out_tag};
        end
    end

    // Called and returning at posedge+1; offers one op until it is taken.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic bi, input logic [TW-1:0] tg);
        int n = 0;
        a = av; b = bv; bin = bi; in_tag = tg; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
            stall_cnt++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 80'(q.size()), 80'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int target);
        int n = 0;
        while (pops < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("pop_count", 80'(pops), 80'(target));
    endtask

    initial begin
        exp_t e;
        int   p0, s0, first_n;

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("in_ready_before_edge", 80'(in_ready), 80'(0));
        @(posedge clk);
        #1 check("in_ready_after_edge", 80'(in_ready), 80'(1));

        e = model(64'd10, 64'd3, 1'b0, 4'd0);
        check("pin_10_3", 80'({e.d, e.bo, e.ov, e.z}), 80'({64'd7, 3'b000}));
        e = model(64'd5, 64'd5, 1'b0, 4'd0);
        check("pin_5_5", 80'({e.d, e.bo, e.ov, e.z}), 80'({64'd0, 3'b001}));
        e = model(64'd0, 64'd1, 1'b0, 4'd0);
        check("pin_0_1", 80'({e.d, e.bo, e.ov, e.z}), 80'({64'hFFFF_FFFF_FFFF_FFFF, 3'b100}));
        e = model(64'h8000_0000_0000_0000, 64'd1, 1'b0, 4'd0);
        check("pin_min_1", 80'({e.d, e.bo, e.ov, e.z}), 80'({64'h7FFF_FFFF_FFFF_FFFF, 3'b010}));
        e = model(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd0);
        check("pin_max_m1", 80'({e.d, e.bo, e.ov, e.z}), 80'({64'h8000_0000_0000_0000, 3'b110}));
        e = model(64'd7, 64'd7, 1'b1, 4'd0);
        check("pin_7_7_b", 80'({e.d, e.bo, e.ov, e.z}), 80'({64'hFFFF_FFFF_FFFF_FFFF, 3'b100}));

        send(64'd10, 64'd3, 1'b0, 4'd1);
        @(negedge clk);
        @(negedge clk);
        check("t1_not_yet", 80'(out_valid), 80'(0));
        @(negedge clk);
        check("t1_latency", 80'(out_valid), 80'(1));
        check("t1_result", 80'({diff, bout, ovf, zero, out_tag}),
              80'({64'd7, 3'b000, 4'd1}));
        @(posedge clk);
        #1;
        send(64'd5, 64'd5, 1'b0, 4'd2);
        repeat (3) @(negedge clk);
        check("t1_zero", 80'({out_valid, diff, zero}), 80'({1'b1, 64'd0, 1'b1}));
        @(posedge clk);
        #1;

        send(64'd0, 64'd1, 1'b0, 4'd3);
        send(64'h8000_0000_0000_0000, 64'd1, 1'b0, 4'd4);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd5);
        send(64'd7, 64'd7, 1'b1, 4'd6);
        send(64'd0, 64'd0, 1'b1, 4'd7);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd8);
        drain();

        rnd_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        rnd_ready = 1'b0;
        or_force  = 1'b1;
        drain();

        p0 = pops;
        or_force = 1'b0;
        for (int k = 0; k < 3; k++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 4'(k));
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; bin = 1'b1;
        in_tag = 4'd3; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("full_blocks", 80'({out_valid, in_ready}), 80'(2'b10));
        end
        or_force = 1'b1;
        @(negedge clk);
        check("full_pass", 80'({out_valid, in_ready}), 80'(2'b11));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        rnd_ready = 1'b1;
        for (int k = 4; k < 8; k++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 4'(k));
        rnd_ready = 1'b0;
        drain();
        check("bp_count", 80'(pops - p0), 80'(8));

        p0 = pops;
        s0 = stall_cnt;
        send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 4'd0);
        first_n = last_acc_n;
        for (int k = 1; k < 100; k++)
            send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 4'(k));
        wait_pops(p0 + 100);
        check("tput_stalls", 80'(stall_cnt - s0), 80'(0));
        check("tput_cycles", 80'(last_pop_n - first_n), 80'(102));
        drain();

        for (int k = 0; k < 3; k++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 4'(k));
        #1 rst_n = 1'b0;
        #1 check("rst_mid", 80'({out_valid, in_ready, diff}), 80'(0));
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 check("rst_rel_before", 80'(in_ready), 80'(0));
        @(posedge clk);
        #1 check("rst_rel_after", 80'(in_ready), 80'(1));
        p0 = pops;
        send(64'd100, 64'd42, 1'b0, 4'd9);
        wait_pops(p0 + 1);
        repeat (3) @(negedge clk);
        check("rst_only_one", 80'(pops - p0), 80'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
